// File: rtl/conv_pkg.sv
// Shared types and sizes for the convolution PE sequencer.
package conv_pkg;

  localparam int CGRP_W = 8;   // channel-group index width
  localparam int PIX_W  = 16;  // output-pixel index width
  localparam int PE_LAT = 3;   // PE latency from last_channel to result strobe

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_CR = 2'd2,
    DRAIN   = 2'd3
  } state_e;

endpackage

// File: rtl/conv_pe_seq_if.sv
// Read/PE/result-FIFO bus between the sequencer (master) and the datapath (slave).
// Signalling: rd_en is a one-cycle read strobe with rd_cgrp/rd_pix valid in the same
// cycle; there is no ready, since the window buffer and weight memory always accept.
// pe_valid/pe_last are rd_en and its last-group flag delayed by the read latency.
// pe_data_valid pulses once per finished pixel; out_pop pulses once per FIFO pop.
interface conv_pe_seq_if;
  import conv_pkg::*;

  logic              rd_en;
  logic [CGRP_W-1:0] rd_cgrp;
  logic [PIX_W-1:0]  rd_pix;
  logic              pe_valid;
  logic              pe_last;
  logic              pe_data_valid;
  logic              out_pop;

  modport master (
    output rd_en, rd_cgrp, rd_pix, pe_valid, pe_last,
    input  pe_data_valid, out_pop
  );

  modport slave (
    input  rd_en, rd_cgrp, rd_pix, pe_valid, pe_last,
    output pe_data_valid, out_pop
  );

endinterface

// File: rtl/conv_vld_delay.sv
// Fixed-depth delay line for the PE valid/last strobes; cleared by reset.
module conv_vld_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q_o = d_i;
    end else begin : g_pipe
      logic [WIDTH-1:0] pipe_q [DEPTH];

      // Shift the strobes one stage per clock
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign q_o = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/conv_pe_seq.sv
// Convolution PE read sequencer: walks channel groups per output pixel, gates each
// new pixel on result-FIFO credit, and counts PE results to close the pass.
// Optional macro CONV_PE_SEQ_PERF_EN adds busy/stall cycle counters.
module conv_pe_seq
  import conv_pkg::*;
#(
  parameter int RD_LAT  = 2,
  parameter int CREDITS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CGRP_W-1:0]            cfg_cgrp_m1,
  input  logic [PIX_W-1:0]             cfg_pix_m1,
  output logic                         busy,
  output logic                         done,
`ifdef CONV_PE_SEQ_PERF_EN
  output logic [31:0]                  perf_busy_cyc,
  output logic [31:0]                  perf_stall_cyc,
`endif
  output state_e                       dbg_state_o,
  output logic [$clog2(CREDITS+1)-1:0] dbg_credit_o,
  conv_pe_seq_if.master                bus
);

  localparam int              CR_W   = $clog2(CREDITS + 1);
  localparam logic [CR_W-1:0] CR_MAX = CR_W'(CREDITS);

  state_e            state_q;
  logic [CGRP_W-1:0] cgrp_m1_q;
  logic [PIX_W-1:0]  pix_m1_q;
  logic              rd_en_q;
  logic [CGRP_W-1:0] rd_cgrp_q;
  logic [PIX_W-1:0]  rd_pix_q;
  logic              done_q;
  logic [CR_W-1:0]   credit_q;
  logic [PIX_W:0]    res_cnt_q;
  logic [PIX_W:0]    res_cnt_d;
  logic [PIX_W:0]    res_total;

  logic last_grp;
  logic last_pix;
  logic want_pix;
  logic consume;

  assign last_grp  = (rd_cgrp_q == cgrp_m1_q);
  assign last_pix  = (rd_pix_q == pix_m1_q);
  assign res_total = {1'b0, pix_m1_q} + 1'b1;
  assign res_cnt_d = res_cnt_q + {{PIX_W{1'b0}}, bus.pe_data_valid};

  // A new pixel is wanted on launch, after the last group of a non-final pixel, or while stalled
  always_comb begin
    want_pix = 1'b0;
    unique case (state_q)
      IDLE:    want_pix = start;
      ISSUE:   want_pix = last_grp && !last_pix;
      WAIT_CR: want_pix = 1'b1;
      default: want_pix = 1'b0;
    endcase
  end

  assign consume = want_pix && (credit_q != '0);

  // Credit counter: pop returns a slot, pixel start takes one, both together cancel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= CR_MAX;
    end else if (consume && !bus.out_pop) begin
      credit_q <= credit_q - 1'b1;
    end else if (!consume && bus.out_pop && (credit_q != CR_MAX)) begin
      credit_q <= credit_q + 1'b1;
    end
  end

  // Sequencer FSM with registered read strobe, indices and done pulse.
  // rd_pix_q always names the pixel to issue next whenever rd_en_q is low mid-pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cgrp_m1_q <= '0;
      pix_m1_q  <= '0;
      rd_en_q   <= 1'b0;
      rd_cgrp_q <= '0;
      rd_pix_q  <= '0;
      done_q    <= 1'b0;
      res_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) res_cnt_q <= res_cnt_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cgrp_m1_q <= cfg_cgrp_m1;
            pix_m1_q  <= cfg_pix_m1;
            res_cnt_q <= '0;
            rd_cgrp_q <= '0;
            rd_pix_q  <= '0;
            rd_en_q   <= consume;
            state_q   <= consume ? ISSUE : WAIT_CR;
          end
        end
        ISSUE: begin
          if (!last_grp) begin
            rd_cgrp_q <= rd_cgrp_q + 1'b1;
          end else if (last_pix) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            rd_cgrp_q <= '0;
            rd_pix_q  <= rd_pix_q + 1'b1;
            if (!consume) begin
              rd_en_q <= 1'b0;
              state_q <= WAIT_CR;
            end
          end
        end
        WAIT_CR: begin
          if (consume) begin
            rd_en_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        DRAIN: begin
          if (res_cnt_d == res_total) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [1:0] vld_in;
  logic [1:0] vld_out;

  assign vld_in = {rd_en_q && last_grp, rd_en_q};

  conv_vld_delay #(
    .DEPTH (RD_LAT),
    .WIDTH (2)
  ) u_vld_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (vld_in),
    .q_o   (vld_out)
  );

  assign bus.rd_en    = rd_en_q;
  assign bus.rd_cgrp  = rd_cgrp_q;
  assign bus.rd_pix   = rd_pix_q;
  assign bus.pe_valid = vld_out[0];
  assign bus.pe_last  = vld_out[1];

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign dbg_state_o  = state_q;
  assign dbg_credit_o = credit_q;

`ifdef CONV_PE_SEQ_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;

  // Saturating busy/stall cycle counters, restarted by each accepted launch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if ((state_q != IDLE) && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 1'b1;
      if ((state_q == WAIT_CR) && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_busy_cyc  = perf_busy_q;
  assign perf_stall_cyc = perf_stall_q;
`endif

endmodule
